// File: rtl/m_ext_pkg.sv
// ---------------------------------------------------------------------------
// m_ext_pkg: shared types and constants for the RV32M execute-path units.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package m_ext_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  // RISC-V results for divide-by-zero and signed overflow quotients.
  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT  = '1;
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_QUOT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational radix-2 restoring division iteration.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  assign w_trial = {rem_i, bit_i};
  // Only consumed when trial >= divisor, so the difference always fits WIDTH bits.
  assign w_diff  = w_trial[WIDTH-1:0] - divisor_i;
  assign qbit_o  = (w_trial >= {1'b0, divisor_i});
  assign rem_o   = qbit_o ? w_diff : w_trial[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module restoring_divider
  import m_ext_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int                 C_CNT_W    = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST     = C_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   C_DZ_QUOT  = WIDTH'($signed(DIV_DZ_QUOT));
  localparam logic [WIDTH-1:0]   C_OVF_QUOT = {DIV_OVF_QUOT[DIV_WIDTH-1], {(WIDTH-1){1'b0}}};

  div_state_t state_q, state_d;

  logic [WIDTH-1:0]   a_mag_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic [WIDTH-1:0]   prem_q;
  logic [WIDTH-1:0]   qsh_q;
  logic [WIDTH-1:0]   orig_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [C_CNT_W-1:0] cnt_q;
  logic               negq_q;
  logic               negr_q;
  logic               dz_q;
  logic               ovf_q;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_dz;
  logic             w_ovf;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;

  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_dz    = (divisor == '0);
  assign w_ovf   = is_signed & (dividend == C_OVF_QUOT) & (divisor == '1);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (a_mag_q[WIDTH-1]),
    .divisor_i(b_mag_q),
    .rem_o    (w_step_rem),
    .qbit_o   (w_step_qbit)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        done = !start;
        if (start) state_d = (w_dz | w_ovf) ? FIXUP : CALC;
      end
      CALC:    if (cnt_q == C_LAST) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      prem_q  <= '0;
      qsh_q   <= '0;
      orig_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            negq_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & !w_dz;
            negr_q  <= w_a_neg;
            a_mag_q <= w_a_neg ? (~dividend + 1'b1) : dividend;
            b_mag_q <= w_b_neg ? (~divisor + 1'b1) : divisor;
            orig_q  <= dividend;
            dz_q    <= w_dz;
            ovf_q   <= w_ovf;
            cnt_q   <= '0;
            prem_q  <= '0;
          end
        end
        CALC: begin
          prem_q  <= w_step_rem;
          qsh_q   <= {qsh_q[WIDTH-2:0], w_step_qbit};
          a_mag_q <= {a_mag_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
        end
        FIXUP: begin
          // Results only ever move here, so they hold across the next operation.
          if (dz_q) begin
            quot_q <= C_DZ_QUOT;
            rem_q  <= orig_q;
          end else if (ovf_q) begin
            quot_q <= C_OVF_QUOT;
            rem_q  <= '0;
          end else begin
            quot_q <= negq_q ? (~qsh_q + 1'b1) : qsh_q;
            rem_q  <= negr_q ? (~prem_q + 1'b1) : prem_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions; the divide counterpart to the combinational multiplier in the M-extension execute path.
- Produces quotient and remainder together in one operation.
- Uses the same start/done handshake as the multiplier, so the execute-stage M-unit controller drives both identically.
- Costs one quotient bit per cycle; RISC-V special cases finish early.

Parameters:
width, 32, operand width in bits (dividend, divisor, quotient, remainder)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start
dividend  input  width  dividend; sampled with start
divisor  input  width  divisor; sampled with start
quotient  output  width  registered quotient
remainder  output  width  registered remainder
done  output  1  combinational status, same convention as the multiplier

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at a clk edge):
  - state <= IDLE.
  - quotient and remainder <= 0.
  - done reads 1 afterwards, provided start is low.
- States (enum): IDLE, CALC, FIXUP, DONE.
- done:
  - IDLE: done = !start, i.e. it drops combinationally in the cycle start is asserted.
  - CALC and FIXUP: done = 0.
  - DONE: done = 1.
- IDLE + start (edge at end of cycle T), latch:
  - neg_q = is_signed & (dividend[msb] ^ divisor[msb]), with divisor nonzero.
  - neg_r = is_signed & dividend[msb].
  - Operand magnitudes: two's-complement negated when is_signed and msb is set.
  - Original dividend, kept for the divide-by-zero result.
  - Special-case flags:
    - dz = (divisor == 0).
    - ovf = is_signed & dividend == 2^(width-1) & divisor == all-ones.
  - Next state: FIXUP if dz or ovf, else CALC with count = 0 and partial remainder = 0.
- CALC: one restoring step per cycle, MSB first.
  - Form trial = {partial_rem[width-1:0], dividend_mag[msb]}, width+1 bits, then shift dividend_mag left.
  - If trial >= divisor_mag: partial_rem <= trial - divisor_mag and the quotient bit is 1.
  - Otherwise: partial_rem <= trial and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient shift register.
  - count increments each step; after width steps (count == width-1 at the edge) go to FIXUP.
  - CALC therefore occupies cycles T+1..T+width.
- FIXUP (one cycle), at the edge:
  - dz: quotient <= all-ones; remainder <= original dividend (signed and unsigned alike).
  - ovf: quotient <= 2^(width-1); remainder <= 0.
  - Otherwise: quotient <= neg_q ? -q : q; remainder <= neg_r ? -r : r.
  - Next state: DONE.
- DONE (one cycle): done = 1; next state IDLE unconditionally. start in the DONE cycle is ignored; it must be re-presented in IDLE.
- Latency from the start edge at end of T to the done=1 cycle:
  - Normal: T+width+2, i.e. T+34 for width 32.
  - dz/ovf: T+2.
- Output stability: quotient and remainder change only at the FIXUP edge. They hold through DONE, IDLE and any subsequent CALC until the next FIXUP.
- start in CALC/FIXUP: ignored; operand inputs are don't-care outside the IDLE start cycle.
- Reset mid-operation: the operation is aborted, state goes to IDLE, and outputs are cleared to 0.
- Remainder sign follows the dividend; quotient truncates toward zero (RISC-V semantics).

Decomposition:
- Shared package m_ext_pkg:
  - div_state_t enum {IDLE, CALC, FIXUP, DONE}.
  - localparam DIV_CYCLES = width.
  - Constants for the RISC-V div-by-zero quotient (all-ones) and the overflow quotient (2^(width-1)).
- One natural sub-module: div_step. It is combinational and does one restoring iteration:
  - Inputs: partial_rem, next dividend bit, divisor_mag.
  - Outputs: new partial_rem, quotient bit.
- Keeping div_step separate allows a later radix-4 or unrolled variant.

Test Plan:
1. Unsigned: start at T with is_signed=0, dividend=100, divisor=7 -> quotient=14, remainder=2. done=0 over T..T+33 and done=1 at T+34.
2. Signed negative dividend: is_signed=1, dividend=0xFFFFFFF9 (-7), divisor=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
3. Divide by zero: dividend=0x00001234, divisor=0, both signed and unsigned -> quotient=0xFFFFFFFF, remainder=0x00001234, done=1 at T+2.
4. Overflow versus unsigned, operands 0x80000000 / 0xFFFFFFFF:
   - Signed -> quotient=0x80000000, remainder=0, done at T+2.
   - Unsigned -> quotient=0, remainder=0x80000000, done at T+34.
5. Reset and ignored start:
   - Start 100/7, pulse start again at T+5, assert rst_n=0 at T+10 -> IDLE, quotient=remainder=0, done=1.
   - A fresh 100/7 afterwards completes correctly.
6. Back-to-back and hold:
   - Re-assert start in the IDLE cycle right after DONE with signed -100/7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
   - The previous results hold until that op's FIXUP edge.
